// File: rtl/exec_sequencer_if.sv
// Request/result handshake bundle between decode, the execute sequencer and
// memory/writeback. The sequencer sits on the slave side of both channels.
interface exec_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              req_flag_en;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_lo;
    logic [DATA_W-1:0] res_hi;

    modport master (
        output req_valid, req_op, req_a, req_b, req_flag_en, res_ready,
        input  req_ready, res_valid, res_lo, res_hi
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_flag_en, res_ready,
        output req_ready, res_valid, res_lo, res_hi
    );
endinterface

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: takes one op at a time from decode, drives the
// neighbouring ALU for single-cycle ops or iterates it DATA_W times as a
// shift-add multiplier, owns the CCR and hands results to writeback.
//
// state | meaning
// IDLE  | ready for a new op from decode
// EXEC  | single ALU cycle, result and flags captured at the edge
// MUL   | one shift-add iteration per cycle, counter counts iterations
// DONE  | result valid, waiting for res_ready
module exec_sequencer #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    exec_sequencer_if.slave   bus,
    output logic [2:0]        alu_operation,
    output logic [DATA_W-1:0] alu_operand1,
    output logic [DATA_W-1:0] alu_operand2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [3:0]        flags,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [2:0]        op_q;
    logic [DATA_W-1:0] a_q;      // operand A, also the multiplicand
    logic [DATA_W-1:0] b_q;      // operand B, reused as the low product half
    logic [DATA_W-1:0] hi_q;
    logic              flag_en_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] res_lo_q;
    logic [DATA_W-1:0] res_hi_q;
    logic [3:0]        flags_q;

    logic              accept;
    logic              mul_last;
    logic [DATA_W-1:0] hi_nx;
    logic [DATA_W-1:0] lo_nx;

    assign accept   = (state == IDLE) && bus.req_valid && !flush;
    assign mul_last = (cnt_q == CNT_W'(DATA_W - 1));

    // The ALU carry becomes the top bit of the shifted partial product so a
    // full-width add never loses its carry-out.
    assign hi_nx = {alu_flags[2], alu_result[DATA_W-1:1]};
    assign lo_nx = {alu_result[0], b_q[DATA_W-1:1]};

    assign bus.req_ready = (state == IDLE);
    assign bus.res_valid = (state == DONE);
    assign bus.res_lo    = res_lo_q;
    assign bus.res_hi    = res_hi_q;
    assign flags         = flags_q;
    assign busy          = (state != IDLE);

    // Next-state selection and ALU drive; ALU inputs are parked at zero
    // outside EXEC/MUL.
    always_comb begin
        state_nx      = state;
        alu_operation = 3'b000;
        alu_operand1  = '0;
        alu_operand2  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = bus.req_op[3] ? MUL : EXEC;
                end
            end
            EXEC: begin
                alu_operation = op_q;
                alu_operand1  = a_q;
                alu_operand2  = b_q;
                state_nx      = DONE;
            end
            MUL: begin
                alu_operation = 3'b000;
                alu_operand1  = hi_q;
                alu_operand2  = b_q[0] ? a_q : '0;
                if (mul_last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush && (state != IDLE)) begin
            state_nx = IDLE;
        end
    end

    // State, operand latch, multiplier datapath, result and CCR registers.
    // An aborted op leaves results and CCR untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            flag_en_q <= 1'b0;
            cnt_q     <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            flags_q   <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= bus.req_op[2:0];
                        a_q       <= bus.req_a;
                        b_q       <= bus.req_b;
                        flag_en_q <= bus.req_flag_en;
                        hi_q      <= '0;
                        cnt_q     <= '0;
                    end
                end
                EXEC: begin
                    if (!flush) begin
                        res_lo_q <= alu_result;
                        res_hi_q <= '0;
                        if (flag_en_q) begin
                            flags_q <= alu_flags;
                        end
                    end
                end
                MUL: begin
                    if (!flush) begin
                        hi_q  <= hi_nx;
                        b_q   <= lo_nx;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (mul_last) begin
                            res_hi_q <= hi_nx;
                            res_lo_q <= lo_nx;
                            if (flag_en_q) begin
                                flags_q <= {2'b00, hi_nx[DATA_W-1],
                                            ({hi_nx, lo_nx} == '0)};
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural 16-bit ALU beside it.
module tb_exec_sequencer;

    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [2:0]        alu_operation;
    logic [DATA_W-1:0] alu_operand1;
    logic [DATA_W-1:0] alu_operand2;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;
    logic [3:0]        flags;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    exec_sequencer_if #(.DATA_W(DATA_W)) bus ();

    exec_sequencer #(.DATA_W(DATA_W), .CNT_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .bus           (bus),
        .alu_operation (alu_operation),
        .alu_operand1  (alu_operand1),
        .alu_operand2  (alu_operand2),
        .alu_result    (alu_result),
        .alu_flags     (alu_flags),
        .flags         (flags),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 pass B, 6 SHL A, 7 NOT A.
    logic [16:0] alu_sum;
    logic        alu_c;
    logic        alu_v;
    always_comb begin
        alu_sum    = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_result = '0;
        case (alu_operation)
            3'd0: begin
                alu_sum    = {1'b0, alu_operand1} + {1'b0, alu_operand2};
                alu_result = alu_sum[15:0];
                alu_c      = alu_sum[16];
                alu_v      = (alu_operand1[15] == alu_operand2[15]) && (alu_result[15] != alu_operand1[15]);
            end
            3'd1: begin
                alu_sum    = {1'b0, alu_operand1} + {1'b0, ~alu_operand2} + 17'd1;
                alu_result = alu_sum[15:0];
                alu_c      = alu_sum[16];
                alu_v      = (alu_operand1[15] != alu_operand2[15]) && (alu_result[15] != alu_operand1[15]);
            end
            3'd2: alu_result = alu_operand1 & alu_operand2;
            3'd3: alu_result = alu_operand1 | alu_operand2;
            3'd4: alu_result = alu_operand1 ^ alu_operand2;
            3'd5: alu_result = alu_operand2;
            3'd6: alu_result = {alu_operand1[14:0], 1'b0};
            default: alu_result = ~alu_operand1;
        endcase
        alu_flags = {alu_v, alu_c, alu_result[15], (alu_result == 16'h0000)};
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        fe;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and wait for its result; consumes it when res_ready=1.
    task automatic run_op(input vec_t v, input string tag);
        int guard;
        int edges;
        int add_cyc;
        int exp_add;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, " req_ready before issue"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid   = 1'b1;
        bus.req_op      = v.op;
        bus.req_a       = v.a;
        bus.req_b       = v.b;
        bus.req_flag_en = v.fe;
        tick();
        bus.req_valid = 1'b0;
        edges   = 1;
        add_cyc = 0;
        while (!bus.res_valid && edges < 40) begin
            if (busy && alu_operation == 3'b000) add_cyc++;
            tick();
            edges++;
        end
        exp_add = v.op[3] ? 16 : ((v.op[2:0] == 3'd0) ? 1 : 0);
        check({tag, " latency"}, 32'(edges), 32'(v.lat));
        check({tag, " add cycles"}, 32'(add_cyc), 32'(exp_add));
        check({tag, " res_lo"}, 32'(bus.res_lo), 32'(v.lo));
        check({tag, " res_hi"}, 32'(bus.res_hi), 32'(v.hi));
        check({tag, " flags"}, 32'(flags), 32'(v.fl));
        if (bus.res_ready) begin
            tick();
            check({tag, " idle after consume"}, {30'd0, busy, bus.req_ready}, 32'b01);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt_v;
        vec_t v;

        // flags column is the running CCR value after each op
        vecs[0] = '{4'h0, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 16'h0000, 4'b1010, 2};
        vecs[1] = '{4'h1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 16'h0000, 4'b0101, 2};
        vecs[2] = '{4'h2, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 16'h0000, 4'b0101, 2};
        vecs[3] = '{4'h4, 16'hFFFF, 16'h0001, 1'b1, 16'hFFFE, 16'h0000, 4'b0010, 2};
        vecs[4] = '{4'h8, 16'h1234, 16'h0010, 1'b1, 16'h2340, 16'h0001, 4'b0000, 17};
        vecs[5] = '{4'h8, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 16'hFFFE, 4'b0010, 17};
        vecs[6] = '{4'h8, 16'h0000, 16'h1234, 1'b1, 16'h0000, 16'h0000, 4'b0001, 17};
        vecs[7] = '{4'hB, 16'h0003, 16'h0005, 1'b0, 16'h000F, 16'h0000, 4'b0001, 17};
        vecs[8] = '{4'h0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 16'h0000, 4'b0101, 2};
        vecs[9] = '{4'h3, 16'h1200, 16'h0034, 1'b0, 16'h1234, 16'h0000, 4'b0101, 2};

        rst             = 1'b1;
        flush           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_op      = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_flag_en = 1'b0;
        bus.res_ready   = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset res_valid", 32'(bus.res_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset flags", 32'(flags), 32'd0);
        check("reset results", {bus.res_hi, bus.res_lo}, 32'd0);
        check("reset alu drive", {13'd0, alu_operation, alu_operand1}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held 5 cycles while a new request is offered.
        bus.res_ready = 1'b0;
        v = '{4'h0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 16'h0000, 4'b0101, 2};
        run_op(v, "bp");
        bus.req_valid = 1'b1;
        bus.req_op    = 4'h0;
        bus.req_a     = 16'h0001;
        bus.req_b     = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp hold %0d", i),
                  {bus.res_valid, bus.req_ready, 14'd0, bus.res_lo}, {2'b10, 14'd0, 16'h2345});
        end
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        check("bp release", {29'd0, busy, bus.res_valid, bus.req_ready}, 32'b001);
        tick();
        check("bp no stray accept", {15'd0, busy, bus.res_lo}, {16'd0, 16'h2345});

        // Flush mid-MUL at counter=9 with CCR=0001.
        run_op(vecs[6], "ccr setup");
        v = '{4'h2, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 16'h0000, 4'b0001, 2};
        run_op(v, "res setup");
        bus.req_valid   = 1'b1;
        bus.req_op      = 4'h8;
        bus.req_a       = 16'h0003;
        bus.req_b       = 16'h0005;
        bus.req_flag_en = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush idle", {30'd0, busy, bus.req_ready}, 32'b01);
        check("flush ccr kept", 32'(flags), 32'b0001);
        check("flush results kept", {bus.res_hi, bus.res_lo}, {16'h0000, 16'h00F0});
        cnt_v = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.res_valid) cnt_v++;
            tick();
        end
        check("flush no res_valid", 32'(cnt_v), 32'd0);

        // Flush in IDLE blocks acceptance.
        bus.req_valid = 1'b1;
        bus.req_op    = 4'h0;
        flush         = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        check("flush blocks accept", 32'(busy), 32'd0);

        // rst and flush together while holding a result in DONE.
        bus.res_ready = 1'b0;
        run_op(vecs[0], "rstflush setup");
        rst   = 1'b1;
        flush = 1'b1;
        tick();
        rst   = 1'b0;
        flush = 1'b0;
        bus.res_ready = 1'b1;
        check("rst+flush state", {29'd0, busy, bus.res_valid, bus.req_ready}, 32'b001);
        check("rst+flush regs", {12'd0, flags, bus.res_lo}, 32'd0);

        // Reset for 2 cycles mid-MUL at counter=7.
        run_op(vecs[0], "rst setup");
        bus.req_valid   = 1'b1;
        bus.req_op      = 4'h8;
        bus.req_a       = 16'hFFFF;
        bus.req_b       = 16'hFFFF;
        bus.req_flag_en = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("midmul rst state", {29'd0, busy, bus.res_valid, bus.req_ready}, 32'b001);
        check("midmul rst flags", 32'(flags), 32'd0);
        check("midmul rst results", {bus.res_hi, bus.res_lo}, 32'd0);
        check("midmul rst alu", {13'd0, alu_operation, alu_operand2}, 32'd0);

        // Fresh MUL after reset must start from clean internal state.
        run_op(vecs[4], "post rst mul");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
